// File: rtl/vlsu_lane_wb_buf.sv
// Lane write-back buffer: a small FIFO between the load unit and one VRF write port.
// Zero-nibble-enable entries are dropped, and a tracker reports when a commit window's retires complete.
module vlsu_lane_wb_buf #(
    parameter int DLEN      = 64,
    parameter int Depth     = 4,
    parameter int IdWidth   = 4,
    parameter int SetWidth  = 6,
    parameter int BankWidth = 2,
    parameter int CntWidth  = 10
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,

    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [IdWidth-1:0]   in_reqId_i,
    input  logic [SetWidth-1:0]  in_vaddr_set_i,
    input  logic [BankWidth-1:0] in_vaddr_bank_i,
    input  logic [DLEN-1:0]      in_data_i,
    input  logic [DLEN/4-1:0]    in_nbe_i,

    output logic                 wr_valid_o,
    input  logic                 wr_ready_i,
    output logic [IdWidth-1:0]   wr_reqId_o,
    output logic [SetWidth-1:0]  wr_set_o,
    output logic [BankWidth-1:0] wr_bank_o,
    output logic [DLEN-1:0]      wr_data_o,
    output logic [DLEN/4-1:0]    wr_nbe_o,

    input  logic                 cmt_valid_i,
    output logic                 cmt_ready_o,
    input  logic [CntWidth-1:0]  cmt_beats_i,
    output logic                 cmt_done_o
);

    // state | meaning
    // IDLE  | no window open; retires accumulate in early; window may start
    // TRACK | window open; rem retires still outstanding
    // DONE  | window finished; cmt_done_o pulses for this one cycle

    localparam int NbeW = DLEN / 4;
    localparam int PtrW = $clog2(Depth);

    localparam logic [CntWidth-1:0] CntOne = {{(CntWidth-1){1'b0}}, 1'b1};
    localparam logic [CntWidth-1:0] CntMax = {CntWidth{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_TRACK,
        ST_DONE
    } state_e;

    logic [PtrW:0]          wr_ptr_q;
    logic [PtrW:0]          rd_ptr_q;
    logic [PtrW-1:0]        wr_idx;
    logic [PtrW-1:0]        rd_idx;
    logic                   empty;
    logic                   full;
    logic                   push;
    logic                   retire;
    logic                   head_live;

    logic [IdWidth-1:0]     id_q   [Depth];
    logic [SetWidth-1:0]    set_q  [Depth];
    logic [BankWidth-1:0]   bank_q [Depth];
    logic [DLEN-1:0]        data_q [Depth];
    logic [NbeW-1:0]        nbe_q  [Depth];

    state_e                 state_q;
    state_e                 state_d;
    logic [CntWidth-1:0]    rem_q;
    logic [CntWidth-1:0]    rem_d;
    logic [CntWidth-1:0]    early_q;
    logic [CntWidth-1:0]    early_d;
    logic [CntWidth-1:0]    early_inc;
    logic [CntWidth:0]      consumed;

    assign wr_idx = wr_ptr_q[PtrW-1:0];
    assign rd_idx = rd_ptr_q[PtrW-1:0];

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_idx == rd_idx) && (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]);

    assign head_live = |nbe_q[rd_idx];

    // A full FIFO refuses input even when the head leaves in the same cycle.
    assign in_ready_o = !full;
    assign push       = in_valid_i && !full;
    assign wr_valid_o = !empty && head_live;
    assign retire     = !empty && (head_live ? wr_ready_i : 1'b1);

    assign wr_reqId_o = id_q[rd_idx];
    assign wr_set_o   = set_q[rd_idx];
    assign wr_bank_o  = bank_q[rd_idx];
    assign wr_data_o  = data_q[rd_idx];
    assign wr_nbe_o   = nbe_q[rd_idx];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (retire) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    // Storage is cleared on reset so the head payload reads as zero.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < Depth; i++) begin
                id_q[i]   <= '0;
                set_q[i]  <= '0;
                bank_q[i] <= '0;
                data_q[i] <= '0;
                nbe_q[i]  <= '0;
            end
        end else if (push) begin
            id_q[wr_idx]   <= in_reqId_i;
            set_q[wr_idx]  <= in_vaddr_set_i;
            bank_q[wr_idx] <= in_vaddr_bank_i;
            data_q[wr_idx] <= in_data_i;
            nbe_q[wr_idx]  <= in_nbe_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            rem_q   <= '0;
            early_q <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            early_q <= early_d;
        end
    end

    assign early_inc = (early_q == CntMax) ? early_q : early_q + CntOne;
    assign consumed  = {1'b0, early_q} + {{CntWidth{1'b0}}, retire};

    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        early_d     = early_q;
        cmt_ready_o = 1'b0;
        cmt_done_o  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cmt_ready_o = 1'b1;
                if (cmt_valid_i) begin
                    // Retires already seen (including this cycle's) count against the window.
                    if ({1'b0, cmt_beats_i} > consumed) begin
                        rem_d   = cmt_beats_i - consumed[CntWidth-1:0];
                        state_d = ST_TRACK;
                    end else begin
                        rem_d   = '0;
                        state_d = ST_DONE;
                    end
                    early_d = '0;
                end else if (retire) begin
                    early_d = early_inc;
                end
            end
            ST_TRACK: begin
                if (retire) begin
                    rem_d = rem_q - CntOne;
                    if (rem_q == CntOne) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                cmt_done_o = 1'b1;
                if (retire) begin
                    early_d = early_inc;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_vlsu_lane_wb_buf.sv
// Bench for vlsu_lane_wb_buf: directed scenarios plus random traffic, all checked
// against a queue-based model of the buffer and commit window.
module tb_vlsu_lane_wb_buf;

    localparam int DLEN  = 64;
    localparam int DEPTH = 4;
    localparam int IDW   = 4;
    localparam int SETW  = 6;
    localparam int BANKW = 2;
    localparam int CNTW  = 10;
    localparam int NBEW  = DLEN / 4;
    localparam int CMAX  = (1 << CNTW) - 1;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [IDW-1:0]   in_id;
    logic [SETW-1:0]  in_set;
    logic [BANKW-1:0] in_bank;
    logic [DLEN-1:0]  in_data;
    logic [NBEW-1:0]  in_nbe;
    logic             wr_valid;
    logic             wr_ready;
    logic [IDW-1:0]   wr_id;
    logic [SETW-1:0]  wr_set;
    logic [BANKW-1:0] wr_bank;
    logic [DLEN-1:0]  wr_data;
    logic [NBEW-1:0]  wr_nbe;
    logic             cmt_valid;
    logic             cmt_ready;
    logic [CNTW-1:0]  cmt_beats;
    logic             cmt_done;

    vlsu_lane_wb_buf #(
        .DLEN(DLEN), .Depth(DEPTH), .IdWidth(IDW), .SetWidth(SETW),
        .BankWidth(BANKW), .CntWidth(CNTW)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_reqId_i(in_id),
        .in_vaddr_set_i(in_set), .in_vaddr_bank_i(in_bank),
        .in_data_i(in_data), .in_nbe_i(in_nbe),
        .wr_valid_o(wr_valid), .wr_ready_i(wr_ready), .wr_reqId_o(wr_id),
        .wr_set_o(wr_set), .wr_bank_o(wr_bank), .wr_data_o(wr_data), .wr_nbe_o(wr_nbe),
        .cmt_valid_i(cmt_valid), .cmt_ready_o(cmt_ready),
        .cmt_beats_i(cmt_beats), .cmt_done_o(cmt_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [IDW-1:0]   id;
        logic [SETW-1:0]  set;
        logic [BANKW-1:0] bank;
        logic [DLEN-1:0]  data;
        logic [NBEW-1:0]  nbe;
    } flit_t;

    flit_t q[$];
    int    phase;       // 0 idle, 1 window open, 2 window just finished
    int    remaining;
    int    early;
    int    vectors;
    int    miscompares;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("in_ready", 64'(in_ready), 64'(q.size() < DEPTH));
        chk("wr_valid", 64'(wr_valid), 64'(q.size() > 0 && q[0].nbe != '0));
        chk("cmt_ready", 64'(cmt_ready), 64'(phase == 0));
        chk("cmt_done", 64'(cmt_done), 64'(phase == 2));
        if (q.size() > 0) begin
            chk("wr_id", 64'(wr_id), 64'(q[0].id));
            chk("wr_set", 64'(wr_set), 64'(q[0].set));
            chk("wr_bank", 64'(wr_bank), 64'(q[0].bank));
            chk("wr_data", 64'(wr_data), 64'(q[0].data));
            chk("wr_nbe", 64'(wr_nbe), 64'(q[0].nbe));
        end
    endtask

    task automatic model_update();
        bit    ret;
        bit    acc;
        int    used;
        flit_t f;
        ret = (q.size() > 0) && (q[0].nbe == '0 || wr_ready);
        acc = in_valid && (q.size() < DEPTH);
        case (phase)
            0: begin
                if (cmt_valid) begin
                    used      = early + (ret ? 1 : 0);
                    remaining = (int'(cmt_beats) > used) ? int'(cmt_beats) - used : 0;
                    early     = 0;
                    phase     = (remaining == 0) ? 2 : 1;
                end else if (ret) begin
                    early = (early < CMAX) ? early + 1 : CMAX;
                end
            end
            1: begin
                if (ret) begin
                    remaining--;
                    if (remaining == 0) phase = 2;
                end
            end
            default: begin
                if (ret) early = (early < CMAX) ? early + 1 : CMAX;
                phase = 0;
            end
        endcase
        if (ret) void'(q.pop_front());
        if (acc) begin
            f.id = in_id; f.set = in_set; f.bank = in_bank; f.data = in_data; f.nbe = in_nbe;
            q.push_back(f);
        end
    endtask

    task automatic step();
        check_outputs();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic set_flit(input logic [NBEW-1:0] nbe);
        in_id   = IDW'($urandom);
        in_set  = SETW'($urandom);
        in_bank = BANKW'($urandom);
        in_data = {$urandom, $urandom};
        in_nbe  = nbe;
    endtask

    task automatic model_reset();
        q.delete();
        phase     = 0;
        remaining = 0;
        early     = 0;
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        model_reset();
        rst_n = 1'b0; in_valid = 1'b0; wr_ready = 1'b0; cmt_valid = 1'b0; cmt_beats = '0;
        in_id = '0; in_set = '0; in_bank = '0; in_data = '0; in_nbe = '0;

        #2;
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        chk("rst_wr_valid", 64'(wr_valid), 64'(0));
        chk("rst_cmt_ready", 64'(cmt_ready), 64'(1));
        chk("rst_cmt_done", 64'(cmt_done), 64'(0));
        chk("rst_wr_data", 64'(wr_data), 64'(0));
        chk("rst_wr_nbe", 64'(wr_nbe), 64'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // commit window of 3 beats, then 3 writes
        cmt_valid = 1'b1; cmt_beats = 10'd3;
        step();
        cmt_valid = 1'b0; wr_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; set_flit(16'hFFFF);
            step();
        end
        in_valid = 1'b0;
        step();
        chk("cmt_done_after_3rd", 64'(cmt_done), 64'(1));
        step();
        chk("cmt_done_one_cycle", 64'(cmt_done), 64'(0));

        // two retires before the window opens
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; set_flit(16'h0F0F);
            step();
        end
        in_valid = 1'b0;
        step();
        cmt_valid = 1'b1; cmt_beats = 10'd2;
        step();
        cmt_valid = 1'b0;
        chk("early_direct_done", 64'(cmt_done), 64'(1));
        step();
        chk("early_done_once", 64'(cmt_done), 64'(0));

        // fill with the write port stalled, then release
        wr_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; set_flit(NBEW'($urandom) | 16'h1);
            step();
        end
        chk("fill_ready_low", 64'(in_ready), 64'(0));
        set_flit(16'hFFFF);
        step();
        step();
        wr_ready = 1'b1;
        step();
        chk("full_retire_no_enq", 64'(q.size()), 64'(3));
        step();
        chk("enq_next_cycle", 64'(q.size()), 64'(3));
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) step();

        // dropped entry followed by a live one
        in_valid = 1'b1; set_flit('0);
        step();
        chk("drop_no_wr_valid", 64'(wr_valid), 64'(0));
        set_flit(16'hFFFF);
        step();
        in_valid = 1'b0;
        chk("live_after_drop", 64'(wr_valid), 64'(1));
        step();

        // random traffic
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom % 3) != 0;
            case ($urandom % 5)
                0:       set_flit('0);
                1:       set_flit('1);
                default: set_flit(NBEW'($urandom));
            endcase
            wr_ready  = $urandom % 2;
            cmt_valid = ($urandom % 8) == 0;
            cmt_beats = CNTW'($urandom_range(0, 6));
            step();
        end
        in_valid = 1'b0; cmt_valid = 1'b0; wr_ready = 1'b1;
        for (int i = 0; i < 8; i++) step();

        // reset with three entries buffered and a window open
        cmt_valid = 1'b1; cmt_beats = 10'd1000;
        step();
        cmt_valid = 1'b0; wr_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; set_flit(16'hFFFF);
            step();
        end
        in_valid = 1'b0; wr_ready = 1'b1;
        chk("pre_rst_track", 64'(cmt_ready), 64'(0));
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("mid_rst_in_ready", 64'(in_ready), 64'(1));
        chk("mid_rst_wr_valid", 64'(wr_valid), 64'(0));
        chk("mid_rst_cmt_ready", 64'(cmt_ready), 64'(1));
        chk("mid_rst_cmt_done", 64'(cmt_done), 64'(0));
        chk("mid_rst_wr_data", 64'(wr_data), 64'(0));
        chk("mid_rst_wr_id", 64'(wr_id), 64'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/vlsu_lane_wb_buf.md
VLSU_LANE_WB_BUF -- requirements
Module: vlsu_lane_wb_buf

Interface
REQ-001 SHALL have parameter DLEN, default 64: lane data width in bits; must be a multiple of 8.
REQ-002 SHALL have parameter Depth, default 4: FIFO entries; must be a power of two and at least 2.
REQ-003 SHALL have parameter IdWidth, default 4: request ID width.
REQ-004 SHALL have parameter SetWidth, default 6: VRF set address width.
REQ-005 SHALL have parameter BankWidth, default 2: VRF bank address width.
REQ-006 SHALL have parameter CntWidth, default 10: commit beat counter width.
REQ-007 SHALL have port clk_i, input, 1: single clock; all logic on its rising edge.
REQ-008 SHALL have port rst_ni, input, 1: reset; asynchronous and active-low.
REQ-009 SHALL have port in_valid_i, input, 1: load-unit lane flit valid.
REQ-010 SHALL have port in_ready_o, output, 1: buffer can accept a flit.
REQ-011 SHALL have port in_reqId_i, input, IdWidth: flit request ID.
REQ-012 SHALL have port in_vaddr_set_i, input, SetWidth: flit VRF set.
REQ-013 SHALL have port in_vaddr_bank_i, input, BankWidth: flit VRF bank.
REQ-014 SHALL have port in_data_i, input, DLEN: flit data.
REQ-015 SHALL have port in_nbe_i, input, DLEN/4: nibble enables; bit i covers data[4i+3:4i].
REQ-016 SHALL have port wr_valid_o, input side of the VRF write port is wr_valid_o, output, 1: VRF write request valid.
REQ-017 SHALL have port wr_ready_i, input, 1: VRF accepts the write.
REQ-018 SHALL have port wr_reqId_o, output, IdWidth: head entry request ID.
REQ-019 SHALL have port wr_set_o, output, SetWidth: head entry VRF set.
REQ-020 SHALL have port wr_bank_o, output, BankWidth: head entry VRF bank.
REQ-021 SHALL have port wr_data_o, output, DLEN: head entry data.
REQ-022 SHALL have port wr_nbe_o, output, DLEN/4: head entry nibble enables.
REQ-023 SHALL have port cmt_valid_i, input, 1: start a commit window.
REQ-024 SHALL have port cmt_ready_o, output, 1: commit window can be started.
REQ-025 SHALL have port cmt_beats_i, input, CntWidth: number of retires that ends the window.
REQ-026 SHALL have port cmt_done_o, output, 1: one-cycle pulse marking end of the window.

Function
REQ-027 SHALL implement a circular FIFO of Depth entries using read and write pointers of log2(Depth)+1 bits, where the MSB is the wrap bit.
REQ-028 SHALL detect empty when the two pointers are equal, and full when the index bits are equal and the wrap bits differ.
REQ-029 SHALL drive in_ready_o = !full, with no bypass: a full FIFO rejects input even if the head retires in the same cycle.
REQ-030 SHALL enqueue on in_valid_i && in_ready_o; a written entry is visible at the head no earlier than the next cycle.
REQ-031 SHALL retire the head entry when the FIFO is not empty and either of these holds:
- head nbe is nonzero and wr_valid_o && wr_ready_i;
- head nbe is all zero (drop): the entry is discarded without asserting wr_valid_o, taking one cycle.
REQ-032 SHALL drive wr_valid_o = !empty && (head nbe != 0).
REQ-033 SHALL drive the wr_* payload outputs directly from the head entry registers.
REQ-034 SHALL keep wr_* payload outputs stable while wr_valid_o is high and wr_ready_i is low.
REQ-035 SHALL allow a simultaneous enqueue and retire when the FIFO is not full; occupancy is then unchanged.
REQ-036 SHALL implement the commit tracker FSM with states IDLE, TRACK and DONE.
REQ-037 SHALL hold cmt_ready_o high only in IDLE.
REQ-038 SHALL handle the IDLE state as follows:
- each retire increments an "early" counter, saturating at its maximum;
- on cmt_valid_i && cmt_ready_o, rem = cmt_beats_i − (early plus any retire in the same cycle), clamped at 0;
- early clears to 0;
- if rem == 0, go to DONE; otherwise go to TRACK.
REQ-039 SHALL handle the TRACK state as follows: each retire decrements rem, and the retire that makes rem 0 moves the FSM to DONE.
REQ-040 SHALL handle the DONE state as follows: assert cmt_done_o for exactly one cycle, then return to IDLE; a retire occurring in DONE counts into early.
REQ-041 SHALL use only CntWidth-bit unsigned arithmetic, with no wrap on decrement (guaranteed by the clamping in REQ-038).

Reset
REQ-042 SHALL, on rst_ni low, asynchronously:
- clear both FIFO pointers to 0;
- set in_ready_o = 1, wr_valid_o = 0, cmt_ready_o = 1, cmt_done_o = 0;
- set the FSM to IDLE, with rem = 0 and early = 0.
REQ-043 SHALL discard buffered entries on reset mid-operation, without producing a VRF write or a done pulse.
REQ-044 SHALL drive the wr_* payload outputs to 0 during reset.

Verification
REQ-045 SHALL be covered by a fill test: with Depth=4 and wr_ready_i=0, push 5 flits -> in_ready_o falls after the 4th, the 5th is held, and data emerges in order once wr_ready_i=1.
REQ-046 SHALL be covered by a drop test: push a flit with nbe=0 then one with nbe=0xFFFF -> wr_valid_o is never high for the first, and the second appears 2 cycles after the first was enqueued.
REQ-047 SHALL be covered by a commit test: cmt_beats_i=3 accepted, then 3 writes with wr_ready_i=1 -> cmt_done_o pulses exactly one cycle after the 3rd write handshake.
REQ-048 SHALL be covered by an early-retire test: 2 writes retire in IDLE, then cmt_beats_i=2 -> FSM goes directly to DONE and cmt_done_o pulses once.
REQ-049 SHALL be covered by a full-FIFO retire test: FIFO full, wr_ready_i=1, in_valid_i=1 -> no enqueue that cycle, and the enqueue occurs the next cycle.
REQ-050 SHALL be covered by a mid-operation reset test: assert rst_ni=0 with 3 entries buffered in TRACK -> outputs take their reset values immediately, and no write or done pulse follows.
